// File: rtl/mandelbrot_pkg.sv
// Shared screen geometry, colour type and writer state encoding for the
// Mandelbrot plotting path.
package mandelbrot_pkg;

  localparam int unsigned SCR_W  = 320;
  localparam int unsigned SCR_H  = 240;
  localparam int unsigned ADDR_W = 17;

  typedef logic [2:0] colour_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    colour_t           colour;
  } pixel_t;

  localparam int unsigned PIXEL_W = $bits(pixel_t);

endpackage

// File: rtl/pixel_fifo.sv
// Circular pixel buffer between the fractal engine and the framebuffer port.
// Storage is left unreset; only the pointers and count are cleared.
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign data_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/plot_writer.sv
// Buffers plotted pixels into a FIFO and streams them to the framebuffer,
// with a full-screen clear sweep that takes over the write port.
//   state   | meaning
//   S_RUN   | drain pixel FIFO to memory, accept plots and clear requests
//   S_CLEAR | sweep every framebuffer address with the latched clear colour
module plot_writer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SCR_W = mandelbrot_pkg::SCR_W,
  parameter int unsigned SCR_H = mandelbrot_pkg::SCR_H
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                plot_i,
  input  logic [8:0]                          x_i,
  input  logic [7:0]                          y_i,
  input  mandelbrot_pkg::colour_t             colour_i,
  input  logic                                clear_i,
  input  mandelbrot_pkg::colour_t             clear_colour_i,
  output logic                                mem_we_o,
  output logic [mandelbrot_pkg::ADDR_W-1:0]   mem_addr_o,
  output mandelbrot_pkg::colour_t             mem_data_o,
  input  logic                                mem_ready_i,
  output logic                                busy_o,
  output logic                                overflow_o,
  output logic [$clog2(DEPTH):0]              level_o
);

  import mandelbrot_pkg::*;

  localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(SCR_W * SCR_H);

  state_t            state_q;
  colour_t           clr_col_q;
  logic [ADDR_W-1:0] sweep_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  colour_t           data_q;
  logic              overflow_q;

  logic   in_range, out_free, run_cmd, flush, push, pop;
  logic   fifo_full, fifo_empty;
  pixel_t push_pix, pop_pix;

  assign in_range = (32'(x_i) < SCR_W) && (32'(y_i) < SCR_H);
  assign out_free = !mem_we_q || mem_ready_i;
  assign run_cmd  = (state_q == S_RUN) && !clear_i;
  assign flush    = (state_q == S_RUN) && clear_i;
  assign pop      = run_cmd && !fifo_empty && out_free;
  assign push     = run_cmd && plot_i && in_range;

  assign push_pix.addr   = ADDR_W'(y_i) * ADDR_W'(SCR_W) + ADDR_W'(x_i);
  assign push_pix.colour = colour_i;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIXEL_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (push_pix),
    .pop_i   (pop),
    .data_o  (pop_pix),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_RUN;
      clr_col_q  <= '0;
      sweep_q    <= '0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (clear_i) begin
            state_q    <= S_CLEAR;
            clr_col_q  <= clear_colour_i;
            overflow_q <= 1'b0;
            // Issue address 0 right away if the port is free; otherwise
            // let the in-flight pixel finish first.
            if (out_free) begin
              mem_we_q <= 1'b1;
              addr_q   <= '0;
              data_q   <= clear_colour_i;
              sweep_q  <= ADDR_W'(1);
            end else begin
              sweep_q  <= '0;
            end
          end else begin
            if (plot_i && in_range && fifo_full && !pop) overflow_q <= 1'b1;
            if (pop) begin
              mem_we_q <= 1'b1;
              addr_q   <= pop_pix.addr;
              data_q   <= pop_pix.colour;
            end else if (out_free) begin
              mem_we_q <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          if (out_free) begin
            if (sweep_q < PIX_TOTAL) begin
              mem_we_q <= 1'b1;
              addr_q   <= sweep_q;
              data_q   <= clr_col_q;
              sweep_q  <= sweep_q + ADDR_W'(1);
            end else begin
              state_q  <= S_RUN;
              mem_we_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign busy_o     = (state_q == S_CLEAR);
  assign overflow_o = overflow_q;

endmodule
